// File: rtl/pwm_deadtime_pkg.sv
// pwm_deadtime_pkg
//   Shared definitions for the PWM dead-time stage: register addresses,
//   CTRL/STATUS bit positions, the per-channel state enum and the default
//   dead-time counter width.
package pwm_deadtime_pkg;

  localparam logic [1:0] ADDR_DT     = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_MASK   = 2'd3;

  localparam int unsigned DT_W_DEFAULT     = 16;
  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_FCLR_BIT    = 1;
  localparam int unsigned STATUS_HI_LSB    = 0;
  localparam int unsigned STATUS_LO_LSB    = 8;
  localparam int unsigned STATUS_DEAD_LSB  = 16;
  localparam int unsigned STATUS_FAULT_BIT = 24;

  typedef enum logic [2:0] {
    CH_OFF         = 3'd0,
    CH_DEAD_TO_HI  = 3'd1,
    CH_HI          = 3'd2,
    CH_DEAD_TO_LO  = 3'd3,
    CH_LO          = 3'd4
  } ch_state_e;

  function automatic logic is_dead(input ch_state_e s);
    return (s == CH_DEAD_TO_HI) || (s == CH_DEAD_TO_LO);
  endfunction

endpackage

// File: rtl/pwm_deadtime_if.sv
// pwm_deadtime_if
//   Register bus shared with the PWM generator.
//   cs      : chip select
//   wr_n    : write strobe, active-low (write = cs & ~wr_n at posedge clk)
//   addr    : register address (2 bits)
//   wr_data : write data (32 bits)
//   rd_data : combinational read data (32 bits), driven by the slave
interface pwm_deadtime_if;
  logic        cs;
  logic        wr_n;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, wr_n, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, wr_n, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/pwm_dt_channel.sv
// pwm_dt_channel
//   One PWM channel turned into a complementary hi/lo gate pair with
//   break-before-make dead time.
//   clk, clr_n : clock, async active-low reset
//   pwm        : PWM level for this channel (same clock domain)
//   enable     : CTRL.en & MASK[i]
//   fault      : force OFF while set
//   dt         : dead time in clk cycles, sampled on dead-state entry
//   hi, lo     : registered gate enables, never both 1
//   dead       : channel is inside a dead interval
module pwm_dt_channel
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            pwm,
  input  logic            enable,
  input  logic            fault,
  input  logic [DT_W-1:0] dt,
  output logic            hi,
  output logic            lo,
  output logic            dead
);

  ch_state_e       state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  // Dead interval was started from OFF, so there is no prior side to fall
  // back to when pwm reverts; the opposite dead interval is started instead.
  logic            from_off_q, from_off_d;
  logic            req_hi, req_lo;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= CH_OFF;
      cnt_q      <= '0;
      from_off_q <= 1'b0;
      hi         <= 1'b0;
      lo         <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_off_q <= from_off_d;
      hi         <= (state_d == CH_HI);
      lo         <= (state_d == CH_LO);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    from_off_d = from_off_q;
    req_hi     = 1'b0;
    req_lo     = 1'b0;

    if (!enable || fault) begin
      state_d    = CH_OFF;
      cnt_d      = '0;
      from_off_d = 1'b0;
    end else begin
      case (state_q)
        CH_OFF: begin
          from_off_d = 1'b1;
          req_hi     = pwm;
          req_lo     = ~pwm;
        end
        CH_LO: begin
          if (pwm) begin
            from_off_d = 1'b0;
            req_hi     = 1'b1;
          end
        end
        CH_HI: begin
          if (!pwm) begin
            from_off_d = 1'b0;
            req_lo     = 1'b1;
          end
        end
        CH_DEAD_TO_HI: begin
          if (!pwm) begin
            if (from_off_q) begin
              req_lo = 1'b1;
            end else begin
              state_d = CH_LO;
              cnt_d   = '0;
            end
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = CH_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        CH_DEAD_TO_LO: begin
          if (pwm) begin
            if (from_off_q) begin
              req_hi = 1'b1;
            end else begin
              state_d = CH_HI;
              cnt_d   = '0;
            end
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = CH_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = CH_OFF;
          cnt_d   = '0;
        end
      endcase

      // A zero dead time hands over on the same edge.
      if (req_hi) begin
        if (dt == '0) begin
          state_d = CH_HI;
          cnt_d   = '0;
        end else begin
          state_d = CH_DEAD_TO_HI;
          cnt_d   = dt;
        end
      end
      if (req_lo) begin
        if (dt == '0) begin
          state_d = CH_LO;
          cnt_d   = '0;
        end else begin
          state_d = CH_DEAD_TO_LO;
          cnt_d   = dt;
        end
      end
    end
  end

  assign dead = is_dead(state_q);

endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
//   Converts N_CH PWM levels into complementary high/low gate enables with
//   a programmable dead time. Holds the DT/CTRL/MASK registers, the STATUS
//   read mux and (optionally) the sticky fault latch.
//   clk, clr_n : clock, async active-low reset
//   bus        : register bus (cs, wr_n, addr, wr_data, rd_data)
//   pwm_in     : PWM levels from the generator
//   fault_n    : only with PWM_DEADTIME_FAULT_EN; active-low, sync to clk
//   hi, lo     : registered gate enables
//   Build option: `define PWM_DEADTIME_FAULT_EN adds fault_n and STATUS[24].
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int unsigned N_CH     = 8,
  parameter int unsigned DT_W     = DT_W_DEFAULT,
  parameter int unsigned DT_RESET = 4
) (
  input  logic            clk,
  input  logic            clr_n,
  pwm_deadtime_if.slave   bus,
  input  logic [N_CH-1:0] pwm_in,
`ifdef PWM_DEADTIME_FAULT_EN
  input  logic            fault_n,
`endif
  output logic [N_CH-1:0] hi,
  output logic [N_CH-1:0] lo
);

  logic [DT_W-1:0] dt_q;
  logic            en_q;
  logic [N_CH-1:0] mask_q;
  logic [N_CH-1:0] dead;
  logic            wr_en;
  logic            fault_q;
  logic            fault_hold;
  logic [31:0]     rd_mux;
  logic            unused_wr_bits;

  assign wr_en          = bus.cs & ~bus.wr_n;
  assign unused_wr_bits = ^bus.wr_data;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dt_q   <= DT_W'(DT_RESET);
      en_q   <= 1'b0;
      mask_q <= '1;
    end else if (wr_en) begin
      case (bus.addr)
        ADDR_DT:   dt_q   <= bus.wr_data[DT_W-1:0];
        ADDR_CTRL: en_q   <= bus.wr_data[CTRL_EN_BIT];
        ADDR_MASK: mask_q <= bus.wr_data[N_CH-1:0];
        default:   ;
      endcase
    end
  end

`ifdef PWM_DEADTIME_FAULT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      fault_q <= 1'b0;
    end else if (!fault_n) begin
      fault_q <= 1'b1;
    end else if (wr_en && (bus.addr == ADDR_CTRL) && bus.wr_data[CTRL_FCLR_BIT]) begin
      fault_q <= 1'b0;
    end
  end

  // The live fault input forces OFF on the same edge it is sampled.
  assign fault_hold = fault_q | ~fault_n;
`else
  assign fault_q    = 1'b0;
  assign fault_hold = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      ADDR_DT:   rd_mux[DT_W-1:0] = dt_q;
      ADDR_CTRL: rd_mux[CTRL_EN_BIT] = en_q;
      ADDR_STATUS: begin
        rd_mux[STATUS_HI_LSB +: N_CH]   = hi;
        rd_mux[STATUS_LO_LSB +: N_CH]   = lo;
        rd_mux[STATUS_DEAD_LSB +: N_CH] = dead;
        rd_mux[STATUS_FAULT_BIT]        = fault_q;
      end
      ADDR_MASK: rd_mux[N_CH-1:0] = mask_q;
      default:   rd_mux = '0;
    endcase
  end

  assign bus.rd_data = rd_mux;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_dt_channel #(
      .DT_W (DT_W)
    ) u_ch (
      .clk    (clk),
      .clr_n  (clr_n),
      .pwm    (pwm_in[i]),
      .enable (en_q & mask_q[i]),
      .fault  (fault_hold),
      .dt     (dt_q),
      .hi     (hi[i]),
      .lo     (lo[i]),
      .dead   (dead[i])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
module tb_pwm_deadtime;
  import pwm_deadtime_pkg::*;

  logic       clk   = 1'b0;
  logic       clr_n = 1'b0;
  logic [7:0] pwm_in = '0;
  logic [7:0] hi, lo;
`ifdef PWM_DEADTIME_FAULT_EN
  logic       fault_n = 1'b1;
`endif

  pwm_deadtime_if bus();

  pwm_deadtime #(
    .N_CH     (8),
    .DT_W     (16),
    .DT_RESET (4)
  ) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .bus    (bus),
    .pwm_in (pwm_in),
`ifdef PWM_DEADTIME_FAULT_EN
    .fault_n(fault_n),
`endif
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // mode: 0 = off, 1 = driving side m_side, 2 = waiting to drive m_side,
  // started at edge m_start for m_len edges.
  int        m_mode   [8] = '{default: 0};
  int        m_side   [8] = '{default: 0};
  longint    m_start  [8] = '{default: 0};
  int        m_len    [8] = '{default: 0};
  bit        m_fromoff[8] = '{default: 0};
  longint    edge_n = 0;
  int        m_dt   = 4;
  bit        m_en   = 0;
  bit [7:0]  m_mask = 8'hFF;
  bit        m_fault = 0;

  task automatic start_xfer(input int i, input bit p, input bit fo);
    if (m_dt == 0) begin
      m_mode[i] = 1;
      m_side[i] = int'(p);
    end else begin
      m_mode[i]    = 2;
      m_side[i]    = int'(p);
      m_start[i]   = edge_n;
      m_len[i]     = m_dt;
      m_fromoff[i] = fo;
    end
  endtask

  task automatic step_ch(input int i, input bit p, input bit run);
    if (!run) begin
      m_mode[i] = 0;
      return;
    end
    case (m_mode[i])
      0: start_xfer(i, p, 1'b1);
      1: if (int'(p) != m_side[i]) start_xfer(i, p, 1'b0);
      default: begin
        if (int'(p) != m_side[i]) begin
          if (m_fromoff[i]) start_xfer(i, p, 1'b1);
          else begin
            m_mode[i] = 1;
            m_side[i] = int'(p);
          end
        end else if (edge_n - m_start[i] == longint'(m_len[i])) begin
          m_mode[i] = 1;
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge clr_n) begin : model
    bit fh;
    bit wr;
    if (!clr_n) begin
      for (int i = 0; i < 8; i++) m_mode[i] = 0;
      m_dt = 4; m_en = 0; m_mask = 8'hFF; m_fault = 0;
    end else begin
      wr = (bus.cs === 1'b1) && (bus.wr_n === 1'b0);
`ifdef PWM_DEADTIME_FAULT_EN
      fh = m_fault || !fault_n;
`else
      fh = 1'b0;
`endif
      for (int i = 0; i < 8; i++) step_ch(i, pwm_in[i], m_en && m_mask[i] && !fh);
`ifdef PWM_DEADTIME_FAULT_EN
      if (!fault_n) m_fault = 1;
      else if (wr && bus.addr == ADDR_CTRL && bus.wr_data[1]) m_fault = 0;
`endif
      if (wr) begin
        if (bus.addr == ADDR_DT)   m_dt   = int'(bus.wr_data[15:0]);
        if (bus.addr == ADDR_CTRL) m_en   = bus.wr_data[0];
        if (bus.addr == ADDR_MASK) m_mask = bus.wr_data[7:0];
      end
      edge_n++;
    end
  end

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s[i]      = (m_mode[i] == 1) && (m_side[i] == 1);
      s[8 + i]  = (m_mode[i] == 1) && (m_side[i] == 0);
      s[16 + i] = (m_mode[i] == 2);
    end
    s[24] = m_fault;
    return s;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Apply one cycle of inputs, then check outputs and STATUS after the edge.
  task automatic cyc(input logic [7:0] p, input bit w, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] want;
    pwm_in      = p;
    bus.cs      = w;
    bus.wr_n    = !w;
    bus.addr    = a;
    bus.wr_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.cs   = 1'b0;
    bus.wr_n = 1'b1;
    bus.addr = ADDR_STATUS;
    #1;
    want = m_status();
    check("status_model", bus.rd_data, want);
    check("hi_model", {24'b0, hi}, {24'b0, want[7:0]});
    check("lo_model", {24'b0, lo}, {24'b0, want[15:8]});
    check("hi_lo_overlap", {24'b0, hi & lo}, 32'h0);
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] want);
    bus.addr = a;
    #1;
    check(name, bus.rd_data, want);
    bus.addr = ADDR_STATUS;
  endtask

  typedef struct {
    logic [7:0]  pwm;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [7:0]  ehi;
    logic [7:0]  elo;
    logic [7:0]  edead;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] p, input bit w, input logic [1:0] a,
                              input logic [31:0] d, input logic [7:0] eh,
                              input logic [7:0] el, input logic [7:0] ed);
    vec_t v;
    v.pwm = p; v.wr = w; v.addr = a; v.data = d;
    v.ehi = eh; v.elo = el; v.edead = ed;
    return v;
  endfunction

  logic [7:0]  rp;
  logic [31:0] rd_snap;
  int          r;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs = 1'b0; bus.wr_n = 1'b1; bus.addr = ADDR_STATUS; bus.wr_data = '0;

    // reset
    cyc(8'h00, 0, ADDR_STATUS, 0);
    cyc(8'h00, 0, ADDR_STATUS, 0);
    clr_n = 1'b1;
    rd("rst_dt", ADDR_DT, 32'd4);
    rd("rst_ctrl", ADDR_CTRL, 32'd0);
    rd("rst_mask", ADDR_MASK, 32'hFF);
    rd("rst_status", ADDR_STATUS, 32'h0);
    check("rst_hilo", {16'b0, hi, lo}, 32'h0);

    // table: pwm, wr, addr, data, exp hi, exp lo, exp dead
    tbl.push_back(mk(8'h00, 1, ADDR_DT,   32'd3, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 1, ADDR_CTRL, 32'd1, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(8'h00, 0, ADDR_DT,   32'd0, 8'h00, 8'h00, 8'hFF));
    tbl.push_back(mk(8'h00, 0, ADDR_DT,   32'd0, 8'h00, 8'h00, 8'hFF));
    tbl.push_back(mk(8'h00, 0, ADDR_DT,   32'd0, 8'h00, 8'h00, 8'hFF));
    tbl.push_back(mk(8'h00, 0, ADDR_DT,   32'd0, 8'h00, 8'hFF, 8'h00));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h00, 8'h7F, 8'h80));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h00, 8'h7F, 8'h80));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h00, 8'h7F, 8'h80));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h80, 1, ADDR_DT,   32'd5, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h81, 0, ADDR_DT,   32'd0, 8'h80, 8'h7E, 8'h01));
    tbl.push_back(mk(8'h81, 0, ADDR_DT,   32'd0, 8'h80, 8'h7E, 8'h01));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h80, 1, ADDR_MASK, 32'h7F, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h80, 1, ADDR_MASK, 32'hFF, 8'h00, 8'h7F, 8'h00));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(8'h80, 0, ADDR_DT, 32'd0, 8'h00, 8'h7F, 8'h80));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h80, 1, ADDR_DT,   32'd0, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h81, 0, ADDR_DT,   32'd0, 8'h81, 8'h7E, 8'h00));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h81, 0, ADDR_DT,   32'd0, 8'h81, 8'h7E, 8'h00));
    tbl.push_back(mk(8'h80, 0, ADDR_DT,   32'd0, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h80, 1, ADDR_DT,   32'd2, 8'h80, 8'h7F, 8'h00));
    tbl.push_back(mk(8'h00, 0, ADDR_DT,   32'd0, 8'h00, 8'h7F, 8'h80));
    tbl.push_back(mk(8'h00, 1, ADDR_DT,   32'd6, 8'h00, 8'h7F, 8'h80));
    tbl.push_back(mk(8'h00, 0, ADDR_DT,   32'd0, 8'h00, 8'hFF, 8'h00));
    tbl.push_back(mk(8'h00, 1, ADDR_CTRL, 32'd0, 8'h00, 8'hFF, 8'h00));
    tbl.push_back(mk(8'h00, 0, ADDR_DT,   32'd0, 8'h00, 8'h00, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].pwm, tbl[i].wr, tbl[i].addr, tbl[i].data);
      rd_snap = bus.rd_data;
      check($sformatf("vec%0d_hi", i), {24'b0, hi}, {24'b0, tbl[i].ehi});
      check($sformatf("vec%0d_lo", i), {24'b0, lo}, {24'b0, tbl[i].elo});
      check($sformatf("vec%0d_dead", i), {24'b0, rd_snap[23:16]}, {24'b0, tbl[i].edead});
    end

    // register corners: STATUS write ignored, unused bits read 0
    cyc(8'h00, 1, ADDR_STATUS, 32'hFFFF_FFFF);
    rd("status_wr_ignored", ADDR_STATUS, 32'h0);
    cyc(8'h00, 1, ADDR_DT, 32'hFFFF_FFFF);
    rd("dt_width", ADDR_DT, 32'h0000_FFFF);
    cyc(8'h00, 1, ADDR_CTRL, 32'hFFFF_FFFE);
    rd("ctrl_width", ADDR_CTRL, 32'h0);
    cyc(8'h00, 1, ADDR_MASK, 32'hFFFF_FF00);
    rd("mask_width", ADDR_MASK, 32'h0);
    cyc(8'h00, 1, ADDR_MASK, 32'hFF);
    cyc(8'h00, 1, ADDR_DT, 32'd3);
    cyc(8'h00, 1, ADDR_CTRL, 32'd1);
    rd("ctrl_rw", ADDR_CTRL, 32'd1);
    for (int i = 0; i < 4; i++) cyc(8'h00, 0, ADDR_DT, 0);
    check("pre_reset_lo", {24'b0, lo}, 32'hFF);

    // asynchronous reset between edges
    #2;
    clr_n = 1'b0;
    #1;
    check("async_rst_hilo", {16'b0, hi, lo}, 32'h0);
    cyc(8'h55, 0, ADDR_DT, 0);
    cyc(8'h55, 0, ADDR_DT, 0);
    clr_n = 1'b1;
    rd("async_rst_dt", ADDR_DT, 32'd4);
    rd("async_rst_ctrl", ADDR_CTRL, 32'd0);

    // randomized phase
    cyc(8'h00, 1, ADDR_DT, 32'd2);
    cyc(8'h00, 1, ADDR_CTRL, 32'd1);
    rp = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) rp[b] = ~rp[b];
`ifdef PWM_DEADTIME_FAULT_EN
      fault_n = ($urandom_range(0, 199) != 0);
`endif
      r = int'($urandom_range(0, 99));
      if (r < 8)       cyc(rp, 1, ADDR_DT, 32'($urandom_range(0, 4)));
      else if (r < 10) cyc(rp, 1, ADDR_MASK, 32'(8'($urandom) | 8'($urandom)));
      else if (r < 12) cyc(rp, 1, ADDR_CTRL,
                           {30'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)});
      else if (r == 12) cyc(rp, 1, ADDR_STATUS, $urandom);
      else             cyc(rp, 0, ADDR_DT, 0);
    end
`ifdef PWM_DEADTIME_FAULT_EN
    fault_n = 1'b1;
    cyc(8'h00, 1, ADDR_CTRL, 32'd3);
`endif

`ifdef PWM_DEADTIME_FAULT_EN
    // fault latch
    cyc(8'h00, 1, ADDR_MASK, 32'hFF);
    cyc(8'h00, 1, ADDR_DT, 32'd3);
    cyc(8'h00, 1, ADDR_CTRL, 32'd1);
    for (int i = 0; i < 6; i++) cyc(8'h00, 0, ADDR_DT, 0);
    check("pre_fault_lo", {24'b0, lo}, 32'hFF);
    fault_n = 1'b0;
    cyc(8'h00, 0, ADDR_DT, 0);
    fault_n = 1'b1;
    check("fault_outputs", {16'b0, hi, lo}, 32'h0);
    rd("fault_sticky", ADDR_STATUS, 32'h0100_0000);
    cyc(8'h00, 0, ADDR_DT, 0);
    cyc(8'h00, 0, ADDR_DT, 0);
    check("fault_hold", {16'b0, hi, lo}, 32'h0);
    cyc(8'h00, 1, ADDR_CTRL, 32'd3);
    rd("fault_cleared", ADDR_STATUS, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h00, 0, ADDR_DT, 0);
      check($sformatf("fault_resume_dead%0d", i), {16'b0, hi, lo}, 32'h0);
    end
    cyc(8'h00, 0, ADDR_DT, 0);
    check("fault_resume_lo", {24'b0, lo}, 32'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
